// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D SPI responder.
// Contents: FSM state type, SPI frame geometry (frame width and the
// channel-field position in the command word) and the default channel
// count and sample width.
package a2d_pkg;

    // Bits per SPI frame, command and data alike.
    localparam int unsigned FRAME_W    = 16;

    // Channel field position inside the 16-bit command word.
    localparam int unsigned CH_MSB     = 13;
    localparam int unsigned CH_LSB     = 11;

    // Default bank geometry.
    localparam int unsigned NUM_CH_DEF = 8;
    localparam int unsigned DATA_W_DEF = 12;

    // Responder transaction states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/a2d_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall detection.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset (chain resets to RST_VAL)
//   sig_i   - asynchronous input pin
//   rise_o  - one-cycle pulse, registered, on a synchronized 0->1
//   fall_o  - one-cycle pulse, registered, on a synchronized 1->0
// A pin change shows up on rise_o/fall_o SYNC_STAGES+1 clocks later.
module a2d_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain; bit 0 takes the raw pin, the MSB is the safe copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(sig_i);
            prev_q <= sync_s;
            rise_q <= sync_s & ~prev_q;
            fall_q <= ~sync_s & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/a2d_spi_resp.sv
// Converter-side SPI responder for the 8-channel, 12-bit A2D link.
// Captures a 16-bit command on MOSI (sampled on SCLK rise), decodes the
// channel from bits [13:11] and returns that channel's sample on MISO
// (changed on SCLK fall) during the following 16-bit frame. Samples come
// from a host-writable bank.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   SS_n       - slave select, active low
//   SCLK       - serial clock, idle high
//   MOSI       - command data from master
//   MISO       - sample data to master (registered)
//   wr_en      - sample-bank write strobe
//   wr_ch      - channel to write
//   wr_data    - sample value to write
//   cmd_vld    - one-cycle pulse when the command frame completes
//   cmd_chnnl  - channel decoded from the last complete command
//   busy       - high whenever the FSM is not IDLE
//   xfer_done  - one-cycle pulse on a clean end of transaction
//   frame_err  - one-cycle pulse when SS_n rises mid-frame
// Build option: define A2D_RESP_INV_EN to send the sample field bitwise
// complemented (pad bits stay 0), matching a master with an inverting
// result path. Left undefined, the sample is sent true.
module a2d_spi_resp #(
    parameter int unsigned NUM_CH      = a2d_pkg::NUM_CH_DEF,
    parameter int unsigned DATA_W      = a2d_pkg::DATA_W_DEF,
    parameter int unsigned FRAME_W     = a2d_pkg::FRAME_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      SS_n,
    input  logic                      SCLK,
    input  logic                      MOSI,
    output logic                      MISO,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)-1:0] wr_ch,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      cmd_vld,
    output logic [2:0]                cmd_chnnl,
    output logic                      busy,
    output logic                      xfer_done,
    output logic                      frame_err
);

    import a2d_pkg::*;

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(FRAME_W);
    localparam int unsigned PAD_W = FRAME_W - DATA_W;
    // Only command bits up to CH_MSB are ever decoded; older bits fall off.
    localparam int unsigned RX_W  = CH_MSB;

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   ss_n_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;

    // SS_n resets high so a reset never looks like a select.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
        end else begin
            ss_sync_q   <= (ss_sync_q << 1) | SYNC_STAGES'(SS_n);
            mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(MOSI);
        end
    end

    assign ss_n_s = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    a2d_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (SCLK),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // ------------------------------------------------------------------
    // Sample bank
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] bank_q [NUM_CH];

    // Host writes; out-of-range channels are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en && (32'(wr_ch) < NUM_CH)) begin
            bank_q[wr_ch] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Command decode and transmit-word build
    // ------------------------------------------------------------------
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RX_W-1:0]    rx_q;
    logic [FRAME_W-1:0] tx_q;
    logic               skip_fall_q;
    logic               miso_q;
    logic               cmd_vld_q;
    logic [2:0]         cmd_chnnl_q;
    logic               busy_q;
    logic               xfer_done_q;
    logic               frame_err_q;

    logic [RX_W:0]        rx_d;
    logic [2:0]           ch_d;
    logic [DATA_W-1:0]    sample_d;
    logic [FRAME_W-1:0]   tx_load_d;
    logic                 last_bit_d;

    // rx_d is the command word as it stands after this rise's MOSI bit;
    // a same-cycle write to the requested channel is forwarded.
    always_comb begin
        rx_d       = {rx_q, mosi_s};
        ch_d       = rx_d[CH_MSB:CH_LSB];
        sample_d   = '0;
        last_bit_d = (cnt_q == CNT_W'(FRAME_W - 1));
        if (32'(ch_d) < NUM_CH) begin
            if (wr_en && (wr_ch == CH_W'(ch_d))) begin
                sample_d = wr_data;
            end else begin
                sample_d = bank_q[CH_W'(ch_d)];
            end
        end
`ifdef A2D_RESP_INV_EN
        tx_load_d = {{PAD_W{1'b0}}, ~sample_d};
`else
        tx_load_d = {{PAD_W{1'b0}}, sample_d};
`endif
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            skip_fall_q <= 1'b0;
            miso_q      <= 1'b0;
            cmd_vld_q   <= 1'b0;
            cmd_chnnl_q <= '0;
            busy_q      <= 1'b0;
            xfer_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cmd_vld_q   <= 1'b0;
            xfer_done_q <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (!ss_n_s) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CMD;
                    end
                end

                CMD: begin
                    if (ss_n_s) begin
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        miso_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (sclk_rise) begin
                        rx_q <= rx_d[RX_W-1:0];
                        if (last_bit_d) begin
                            cmd_chnnl_q <= ch_d;
                            cmd_vld_q   <= 1'b1;
                            tx_q        <= tx_load_d;
                            skip_fall_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= DATA;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                DATA: begin
                    if (ss_n_s) begin
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        miso_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        miso_q <= tx_q[FRAME_W-1];
                        // First fall opens the data frame while bit 15 is
                        // already on the wire; it must survive the next rise.
                        if (sclk_fall) begin
                            if (skip_fall_q) begin
                                skip_fall_q <= 1'b0;
                            end else begin
                                tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
                            end
                        end
                        if (sclk_rise) begin
                            if (last_bit_d) begin
                                cnt_q   <= '0;
                                state_q <= DONE;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end

                DONE: begin
                    miso_q <= 1'b0;
                    if (ss_n_s) begin
                        xfer_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    miso_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign MISO      = miso_q;
    assign cmd_vld   = cmd_vld_q;
    assign cmd_chnnl = cmd_chnnl_q;
    assign busy      = busy_q;
    assign xfer_done = xfer_done_q;
    assign frame_err = frame_err_q;

endmodule
